// File: rtl/branch_resolver.sv
// In-flight branch queue: allocates predicted branches, records resolutions, retires in order.
// Optional BRANCH_STATS_EN adds retire/mispredict counters.
module branch_resolver #(
    parameter int QUEUE_WIDTH = 3
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   alloc_valid,
    input  logic [31:0]            alloc_pc,
    input  logic                   alloc_pred_jump,
    output logic                   alloc_ready,
    output logic [QUEUE_WIDTH-1:0] alloc_tag,
    input  logic                   res_valid,
    input  logic [QUEUE_WIDTH-1:0] res_tag,
    input  logic                   res_jump,
    input  logic [31:0]            res_target,
    output logic                   update_control,
    output logic                   update_jump,
    output logic [31:0]            update_pc,
    output logic                   flush,
`ifdef BRANCH_STATS_EN
    output logic [31:0]            stat_retired,
    output logic [31:0]            stat_mispredict,
`endif
    output logic [31:0]            redirect_pc
);

    localparam int DEPTH = 2 ** QUEUE_WIDTH;
    localparam logic [QUEUE_WIDTH:0] DEPTH_C = (QUEUE_WIDTH + 1)'(DEPTH);

    logic [DEPTH-1:0]       valid_q, valid_d, resolved_q, resolved_d;
    logic [DEPTH-1:0]       pred_q, actual_q;
    logic [31:0]            pc_q [DEPTH];
    logic [31:0]            target_q [DEPTH];
    logic [QUEUE_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [QUEUE_WIDTH:0]   count_q, count_d;
    logic                   update_control_q, update_control_d;
    logic                   update_jump_q, update_jump_d;
    logic [31:0]            update_pc_q, update_pc_d;
    logic                   flush_q, flush_d;
    logic [31:0]            redirect_pc_q, redirect_pc_d;

    logic retire_s, mispred_s, do_alloc_s, do_res_s;

    // Allocation is gated on registered count, so a slot freed this edge is not reused.
    assign retire_s   = rdy_in & valid_q[head_q] & resolved_q[head_q];
    assign mispred_s  = retire_s & (actual_q[head_q] != pred_q[head_q]);
    assign do_alloc_s = rdy_in & alloc_valid & (count_q != DEPTH_C) & ~mispred_s;
    assign do_res_s   = rdy_in & res_valid & valid_q[res_tag] & ~resolved_q[res_tag] & ~mispred_s;

    assign alloc_ready    = (count_q != DEPTH_C);
    assign alloc_tag      = tail_q;
    assign update_control = update_control_q;
    assign update_jump    = update_jump_q;
    assign update_pc      = update_pc_q;
    assign flush          = flush_q;
    assign redirect_pc    = redirect_pc_q;

    // Next-state for queue control and the registered retire/flush outputs.
    always_comb begin
        valid_d          = valid_q;
        resolved_d       = resolved_q;
        head_d           = head_q;
        tail_d           = tail_q;
        count_d          = count_q;
        update_control_d = 1'b0;
        update_jump_d    = update_jump_q;
        update_pc_d      = update_pc_q;
        flush_d          = 1'b0;
        redirect_pc_d    = redirect_pc_q;

        if (retire_s) begin
            update_control_d = 1'b1;
            update_jump_d    = actual_q[head_q];
            update_pc_d      = pc_q[head_q];
        end else begin
            update_control_d = 1'b0;
        end

        if (mispred_s) begin
            valid_d       = '0;
            resolved_d    = '0;
            head_d        = tail_q;
            count_d       = '0;
            flush_d       = 1'b1;
            redirect_pc_d = actual_q[head_q] ? target_q[head_q] : (pc_q[head_q] + 32'd4);
        end else begin
            if (retire_s) begin
                valid_d[head_q]    = 1'b0;
                resolved_d[head_q] = 1'b0;
                head_d             = head_q + QUEUE_WIDTH'(1);
            end else begin
                head_d = head_q;
            end
            if (do_alloc_s) begin
                valid_d[tail_q]    = 1'b1;
                resolved_d[tail_q] = 1'b0;
                tail_d             = tail_q + QUEUE_WIDTH'(1);
            end else begin
                tail_d = tail_q;
            end
            if (do_res_s) begin
                resolved_d[res_tag] = 1'b1;
            end else begin
                resolved_d[res_tag] = resolved_d[res_tag];
            end
            count_d = count_q + (QUEUE_WIDTH + 1)'(do_alloc_s) - (QUEUE_WIDTH + 1)'(retire_s);
        end
    end

    // Control state and output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q          <= '0;
            resolved_q       <= '0;
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            update_control_q <= 1'b0;
            update_jump_q    <= 1'b0;
            update_pc_q      <= 32'd0;
            flush_q          <= 1'b0;
            redirect_pc_q    <= 32'd0;
        end else begin
            valid_q          <= valid_d;
            resolved_q       <= resolved_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            update_control_q <= update_control_d;
            update_jump_q    <= update_jump_d;
            update_pc_q      <= update_pc_d;
            flush_q          <= flush_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    // Entry payload; only meaningful while the matching valid bit is set.
    always_ff @(posedge clk_in) begin
        if (do_alloc_s) begin
            pc_q[tail_q]   <= alloc_pc;
            pred_q[tail_q] <= alloc_pred_jump;
        end
        if (do_res_s) begin
            actual_q[res_tag] <= res_jump;
            target_q[res_tag] <= res_target;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_retired_q, stat_mispredict_q;

    // Wrapping retire and mispredict counters.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stat_retired_q    <= 32'd0;
            stat_mispredict_q <= 32'd0;
        end else begin
            stat_retired_q    <= stat_retired_q + 32'(retire_s);
            stat_mispredict_q <= stat_mispredict_q + 32'(mispred_s);
        end
    end

    assign stat_retired    = stat_retired_q;
    assign stat_mispredict = stat_mispredict_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed testbench for branch_resolver (QUEUE_WIDTH=3); stats checks when BRANCH_STATS_EN is defined.
module tb_branch_resolver;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        alloc_valid, alloc_pred_jump, alloc_ready;
    logic [31:0] alloc_pc;
    logic [2:0]  alloc_tag;
    logic        res_valid, res_jump;
    logic [2:0]  res_tag;
    logic [31:0] res_target;
    logic        update_control, update_jump, flush;
    logic [31:0] update_pc, redirect_pc;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_retired, stat_mispredict;
`endif

    int total = 0;
    int bad = 0;

    branch_resolver #(.QUEUE_WIDTH(3)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_pred_jump(alloc_pred_jump),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .res_valid(res_valid), .res_tag(res_tag), .res_jump(res_jump), .res_target(res_target),
        .update_control(update_control), .update_jump(update_jump), .update_pc(update_pc),
        .flush(flush),
`ifdef BRANCH_STATS_EN
        .stat_retired(stat_retired), .stat_mispredict(stat_mispredict),
`endif
        .redirect_pc(redirect_pc)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rst_in = 1'b0; rdy_in = 1'b1;
        alloc_valid = 1'b0; alloc_pc = 32'd0; alloc_pred_jump = 1'b0;
        res_valid = 1'b0; res_tag = 3'd0; res_jump = 1'b0; res_target = 32'd0;
    endtask

    task automatic do_alloc(input logic [31:0] pc, input logic pred);
        alloc_valid = 1'b1; alloc_pc = pc; alloc_pred_jump = pred;
        tick();
        idle();
    endtask

    task automatic do_res(input logic [2:0] tag, input logic jump, input logic [31:0] tgt);
        res_valid = 1'b1; res_tag = tag; res_jump = jump; res_target = tgt;
        tick();
        idle();
    endtask

    task automatic do_reset();
        idle(); rst_in = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", alloc_ready); end
        total++; if (alloc_tag !== 3'd0) begin bad++; $display("FAIL reset_tag got=%0d want=0", alloc_tag); end
        total++; if (update_control !== 1'b0 || flush !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%0b%0b want=00", update_control, flush); end
        total++; if (update_pc !== 32'd0 || redirect_pc !== 32'd0) begin bad++; $display("FAIL reset_pcs got=%h/%h want=0/0", update_pc, redirect_pc); end
    endtask

    task automatic test_correct();
        do_alloc(32'h100, 1'b1);
        total++; if (alloc_tag !== 3'd1) begin bad++; $display("FAIL corr_tag got=%0d want=1", alloc_tag); end
        do_res(3'd0, 1'b1, 32'h500);
        total++; if (update_control !== 1'b0) begin bad++; $display("FAIL corr_early got=%0b want=0", update_control); end
        tick();
        total++; if (update_control !== 1'b1 || update_jump !== 1'b1 || update_pc !== 32'h100 || flush !== 1'b0)
            begin bad++; $display("FAIL corr_update got=%0b/%0b/%h/%0b want=1/1/100/0", update_control, update_jump, update_pc, flush); end
        tick();
        total++; if (update_control !== 1'b0) begin bad++; $display("FAIL corr_pulse got=%0b want=0", update_control); end
    endtask

    task automatic test_mispredict();
        total++; if (alloc_tag !== 3'd1) begin bad++; $display("FAIL mis_tag got=%0d want=1", alloc_tag); end
        do_alloc(32'h200, 1'b1);
        do_res(3'd1, 1'b0, 32'h999);
        tick();
        total++; if (flush !== 1'b1 || redirect_pc !== 32'h204 || update_control !== 1'b1 || update_jump !== 1'b0 || update_pc !== 32'h200)
            begin bad++; $display("FAIL mis_nt got=%0b/%h/%0b/%0b/%h want=1/204/1/0/200", flush, redirect_pc, update_control, update_jump, update_pc); end
        total++; if (alloc_ready !== 1'b1 || alloc_tag !== 3'd2) begin bad++; $display("FAIL mis_ptr got=%0b/%0d want=1/2", alloc_ready, alloc_tag); end
        tick();
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL mis_pulse got=%0b want=0", flush); end
        do_alloc(32'h300, 1'b0);
        do_res(3'd2, 1'b1, 32'h1234);
        tick();
        total++; if (flush !== 1'b1 || redirect_pc !== 32'h1234 || alloc_tag !== 3'd3)
            begin bad++; $display("FAIL mis_tk got=%0b/%h/%0d want=1/1234/3", flush, redirect_pc, alloc_tag); end
        tick();
    endtask

    task automatic test_order();
        do_alloc(32'h1000, 1'b1);
        do_alloc(32'h1004, 1'b1);
        do_alloc(32'h1008, 1'b1);
        do_res(3'd5, 1'b1, 32'h0);
        do_res(3'd4, 1'b1, 32'h0);
        total++; if (update_control !== 1'b0) begin bad++; $display("FAIL ord_wait got=%0b want=0", update_control); end
        do_res(3'd3, 1'b1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (update_control !== 1'b1 || update_pc !== 32'h1000 + 32'(4 * i))
                begin bad++; $display("FAIL ord_retire%0d got=%0b/%h want=1/%h", i, update_control, update_pc, 32'h1000 + 32'(4 * i)); end
        end
        tick();
        total++; if (update_control !== 1'b0 || alloc_tag !== 3'd6) begin bad++; $display("FAIL ord_end got=%0b/%0d want=0/6", update_control, alloc_tag); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) do_alloc(32'h2000 + 32'(4 * i), 1'b1);
        total++; if (alloc_ready !== 1'b0 || alloc_tag !== 3'd0) begin bad++; $display("FAIL full_ready got=%0b/%0d want=0/0", alloc_ready, alloc_tag); end
        do_alloc(32'hDEAD, 1'b1);
        total++; if (alloc_ready !== 1'b0 || alloc_tag !== 3'd0) begin bad++; $display("FAIL full_drop got=%0b/%0d want=0/0", alloc_ready, alloc_tag); end
        do_res(3'd0, 1'b1, 32'h0);
        tick();
        total++; if (update_control !== 1'b1 || update_pc !== 32'h2000 || alloc_ready !== 1'b1 || alloc_tag !== 3'd0)
            begin bad++; $display("FAIL full_free got=%0b/%h/%0b/%0d want=1/2000/1/0", update_control, update_pc, alloc_ready, alloc_tag); end
        do_alloc(32'h3000, 1'b1);
        total++; if (alloc_ready !== 1'b0 || alloc_tag !== 3'd1) begin bad++; $display("FAIL full_wrap got=%0b/%0d want=0/1", alloc_ready, alloc_tag); end
        for (int i = 1; i <= 8; i++) begin
            do_res(3'(i % 8), 1'b1, 32'h0);
            if (i >= 2) begin
                total++; if (update_control !== 1'b1 || update_pc !== 32'h2000 + 32'(4 * (i - 1)))
                    begin bad++; $display("FAIL full_drain%0d got=%0b/%h want=1/%h", i - 1, update_control, update_pc, 32'h2000 + 32'(4 * (i - 1))); end
            end
        end
        tick();
        total++; if (update_control !== 1'b1 || update_pc !== 32'h3000) begin bad++; $display("FAIL full_last got=%0b/%h want=1/3000", update_control, update_pc); end
        tick();
        total++; if (update_control !== 1'b0 || alloc_ready !== 1'b1) begin bad++; $display("FAIL full_empty got=%0b/%0b want=0/1", update_control, alloc_ready); end
    endtask

    task automatic test_collision_stall();
        do_reset();
        do_alloc(32'h400, 1'b1);
        do_alloc(32'h404, 1'b1);
        do_res(3'd0, 1'b0, 32'h0);
        alloc_valid = 1'b1; alloc_pc = 32'h408; alloc_pred_jump = 1'b1;
        res_valid = 1'b1; res_tag = 3'd1; res_jump = 1'b1; res_target = 32'h0;
        tick();
        idle();
        total++; if (flush !== 1'b1 || redirect_pc !== 32'h404 || alloc_tag !== 3'd2)
            begin bad++; $display("FAIL coll_flush got=%0b/%h/%0d want=1/404/2", flush, redirect_pc, alloc_tag); end
        do_res(3'd1, 1'b1, 32'h0);
        tick();
        total++; if (update_control !== 1'b0 || alloc_tag !== 3'd2) begin bad++; $display("FAIL coll_discard got=%0b/%0d want=0/2", update_control, alloc_tag); end
        do_alloc(32'h500, 1'b1);
        do_res(3'd2, 1'b1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            rdy_in = 1'b0; alloc_valid = 1'b1; alloc_pc = 32'h777;
            tick();
            total++; if (update_control !== 1'b0 || alloc_tag !== 3'd3) begin bad++; $display("FAIL stall%0d got=%0b/%0d want=0/3", i, update_control, alloc_tag); end
        end
        idle();
        tick();
        total++; if (update_control !== 1'b1 || update_pc !== 32'h500 || alloc_tag !== 3'd3)
            begin bad++; $display("FAIL stall_resume got=%0b/%h/%0d want=1/500/3", update_control, update_pc, alloc_tag); end
        tick();
    endtask

    task automatic test_reset_midflight();
        do_alloc(32'h600, 1'b1);
        do_res(3'd3, 1'b1, 32'h0);
        rst_in = 1'b1;
        tick();
        total++; if (update_control !== 1'b0 || alloc_tag !== 3'd0) begin bad++; $display("FAIL rstmid got=%0b/%0d want=0/0", update_control, alloc_tag); end
        idle();
        tick();
        total++; if (update_control !== 1'b0 || alloc_ready !== 1'b1) begin bad++; $display("FAIL rstmid_after got=%0b/%0b want=0/1", update_control, alloc_ready); end
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 4; i++) do_alloc(32'h700 + 32'(4 * i), 1'b1);
        do_res(3'd0, 1'b1, 32'h0);
        do_res(3'd1, 1'b1, 32'h0);
        do_res(3'd2, 1'b1, 32'h0);
        do_res(3'd3, 1'b0, 32'h0);
        tick(); tick();
        total++; if (stat_retired !== 32'd4 || stat_mispredict !== 32'd1)
            begin bad++; $display("FAIL stats got=%0d/%0d want=4/1", stat_retired, stat_mispredict); end
        do_reset();
        total++; if (stat_retired !== 32'd0 || stat_mispredict !== 32'd0)
            begin bad++; $display("FAIL stats_reset got=%0d/%0d want=0/0", stat_retired, stat_mispredict); end
    endtask
`endif

    initial begin
        idle();
        test_reset();
        test_correct();
        test_mispredict();
        test_order();
        test_full();
        test_collision_stall();
        test_reset_midflight();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
